pe_rp: RTL and testbench

PE_RP -- requirements
Module: pe_rp

---
 rtl/pe_rp.sv | 176 +++++++++++++++++
 tb/tb_pe_rp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pe_rp.sv
// Processing element: gemm multiply-accumulate or piecewise-linear unary function
// (div/exp/log) through a two-stage pipeline with saturating ACC_BW result.
module pe_rp #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int SEG_BW = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode_i,
    input  logic                     valid_i,
    input  logic signed [ACC_BW-1:0] mac_i,
    input  logic signed [ACC_BW-1:0] o_i,
    input  logic signed [MUL_BW-1:0] x_i,
    input  logic signed [MUL_BW-1:0] wc_i,
    input  logic                     cfg_we_i,
    input  logic [SEG_BW+1:0]        cfg_addr_i,
    input  logic signed [MUL_BW-1:0] cfg_scale_i,
    input  logic signed [ACC_BW-1:0] cfg_offset_i,
    output logic                     valid_o,
    output logic signed [ACC_BW-1:0] o_o,
    output logic signed [ACC_BW-1:0] mac_o,
    output logic signed [MUL_BW-1:0] wc_o,
    output logic                     sat_o
);

    localparam int NSEG    = 1 << SEG_BW;
    localparam int PROD_BW = 2 * MUL_BW;
    localparam int SUM_BW  = ((PROD_BW > ACC_BW) ? PROD_BW : ACC_BW) + 1;
    localparam logic [1:0] MODE_GEMM = 2'b00;

    if (INT_BW + FRA_BW + 1 != MUL_BW) begin : g_fmt_check
        $error("pe_rp: Q(INT_BW.FRA_BW) plus sign must fill MUL_BW");
    end

    // PWL tables: index 0/1/2 serve div/exp/log
    logic signed [MUL_BW-1:0] scale_tbl_q  [3][NSEG];
    logic signed [ACC_BW-1:0] offset_tbl_q [3][NSEG];

    logic [1:0]        wr_sel;
    logic [SEG_BW-1:0] wr_seg;
    logic [SEG_BW-1:0] rd_seg;
    assign wr_sel = cfg_addr_i[SEG_BW+1:SEG_BW];
    assign wr_seg = cfg_addr_i[SEG_BW-1:0];
    assign rd_seg = x_i[MUL_BW-1 -: SEG_BW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < 3; t++) begin
                for (int s = 0; s < NSEG; s++) begin
                    scale_tbl_q[t][s]  <= '0;
                    offset_tbl_q[t][s] <= '0;
                end
            end
        end else if (cfg_we_i && wr_sel != 2'b11) begin
            scale_tbl_q[wr_sel][wr_seg]  <= cfg_scale_i;
            offset_tbl_q[wr_sel][wr_seg] <= cfg_offset_i;
        end
    end

    logic signed [MUL_BW-1:0] lut_scale_d;
    logic signed [ACC_BW-1:0] lut_offset_d;
    always_comb begin
        lut_scale_d  = '0;
        lut_offset_d = '0;
        case (mode_i)
            2'b01: begin
                lut_scale_d  = scale_tbl_q[0][rd_seg];
                lut_offset_d = offset_tbl_q[0][rd_seg];
            end
            2'b10: begin
                lut_scale_d  = scale_tbl_q[1][rd_seg];
                lut_offset_d = offset_tbl_q[1][rd_seg];
            end
            2'b11: begin
                lut_scale_d  = scale_tbl_q[2][rd_seg];
                lut_offset_d = offset_tbl_q[2][rd_seg];
            end
            default: ;
        endcase
    end

    // Integer part of the unary operand, saturated into the multiplier range
    logic signed [ACC_BW-1:0]  mac_sh;
    logic [ACC_BW-MUL_BW:0]    mac_hi;
    logic signed [MUL_BW-1:0]  mac_t_d;
    assign mac_sh = mac_i >>> FRA_BW;
    assign mac_hi = mac_sh[ACC_BW-1:MUL_BW-1];
    always_comb begin
        if (&mac_hi || ~|mac_hi) begin
            mac_t_d = mac_sh[MUL_BW-1:0];
        end else if (mac_sh[ACC_BW-1]) begin
            mac_t_d = {1'b1, {(MUL_BW-1){1'b0}}};
        end else begin
            mac_t_d = {1'b0, {(MUL_BW-1){1'b1}}};
        end
    end

    logic                     v1_q;
    logic [1:0]               mode_q;
    logic signed [MUL_BW-1:0] wreg_q, ireg_q, mac_t_q, scale_q;
    logic signed [ACC_BW-1:0] add_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            mode_q  <= '0;
            wreg_q  <= '0;
            ireg_q  <= '0;
            mac_t_q <= '0;
            scale_q <= '0;
            add_q   <= '0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                mode_q <= mode_i;
                if (mode_i == MODE_GEMM) begin
                    wreg_q <= wc_i;
                    ireg_q <= x_i;
                    add_q  <= o_i;
                end else begin
                    mac_t_q <= mac_t_d;
                    scale_q <= lut_scale_d;
                    add_q   <= lut_offset_d;
                end
            end
        end
    end

    logic signed [MUL_BW-1:0]  op_a, op_b;
    logic signed [PROD_BW-1:0] prod;
    logic signed [SUM_BW-1:0]  sum;
    logic [SUM_BW-ACC_BW:0]    sum_hi;
    logic                      ovf_d;
    logic signed [ACC_BW-1:0]  res_d;

    assign op_a   = (mode_q == MODE_GEMM) ? wreg_q : scale_q;
    assign op_b   = (mode_q == MODE_GEMM) ? ireg_q : mac_t_q;
    assign prod   = PROD_BW'(op_a) * PROD_BW'(op_b);
    assign sum    = SUM_BW'(prod) + SUM_BW'(add_q);
    assign sum_hi = sum[SUM_BW-1:ACC_BW-1];
    assign ovf_d  = !(&sum_hi || ~|sum_hi);

    always_comb begin
        res_d = sum[ACC_BW-1:0];
        if (ovf_d) begin
            res_d = sum[SUM_BW-1] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
        end
    end

    logic                     valid_q, sat_q;
    logic signed [ACC_BW-1:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= v1_q;
            sat_q   <= v1_q & ovf_d;
            if (v1_q) begin
                res_q <= res_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign sat_o   = sat_q;
    assign o_o     = res_q;
    assign mac_o   = res_q;
    assign wc_o    = wreg_q;

endmodule

// File: tb/tb_pe_rp.sv
// Directed testbench for pe_rp: gemm, saturation, PWL lookups, table
// read-during-write, mixed-mode back-to-back traffic and mid-operation reset.
module tb_pe_rp;

    logic               clk;
    logic               rst_n;
    logic [1:0]         mode_i;
    logic               valid_i;
    logic signed [31:0] mac_i, o_i;
    logic signed [15:0] x_i, wc_i;
    logic               cfg_we_i;
    logic [4:0]         cfg_addr_i;
    logic signed [15:0] cfg_scale_i;
    logic signed [31:0] cfg_offset_i;
    logic               valid_o;
    logic signed [31:0] o_o, mac_o;
    logic signed [15:0] wc_o;
    logic               sat_o;

    int n_cmp = 0;
    int n_bad = 0;

    pe_rp #(.INT_BW(5), .FRA_BW(10), .MUL_BW(16), .ACC_BW(32), .SEG_BW(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_i(valid_i),
        .mac_i(mac_i), .o_i(o_i), .x_i(x_i), .wc_i(wc_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_scale_i(cfg_scale_i), .cfg_offset_i(cfg_offset_i),
        .valid_o(valid_o), .o_o(o_o), .mac_o(mac_o), .wc_o(wc_o), .sat_o(sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] m, input logic signed [15:0] x, input logic signed [15:0] w,
                            input logic signed [31:0] mac, input logic signed [31:0] o);
        mode_i = m; x_i = x; wc_i = w; mac_i = mac; o_i = o; valid_i = 1'b1;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic signed [15:0] sc, input logic signed [31:0] off);
        cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_scale_i = sc; cfg_offset_i = off;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        if (valid_o !== 1'b0) begin $display("FAIL rst_valid got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd0)   begin $display("FAIL rst_o got=%0d exp=0", o_o); n_bad++; end n_cmp++;
        if (mac_o !== 32'sd0) begin $display("FAIL rst_mac got=%0d exp=0", mac_o); n_bad++; end n_cmp++;
        if (wc_o !== 16'sd0)  begin $display("FAIL rst_wc got=%0d exp=0", wc_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b0)   begin $display("FAIL rst_sat got=%0d exp=0", sat_o); n_bad++; end n_cmp++;
        rst_n = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_gemm();
        drive_op(2'b00, 16'sd4, 16'sd3, 32'sd0, 32'sd10);
        tick(); valid_i = 1'b0;
        if (wc_o !== 16'sd3)  begin $display("FAIL gemm_wc got=%0d exp=3", wc_o); n_bad++; end n_cmp++;
        if (valid_o !== 1'b0) begin $display("FAIL gemm_early_valid got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        tick();
        if (valid_o !== 1'b1) begin $display("FAIL gemm_valid got=%0d exp=1", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd22)  begin $display("FAIL gemm_o got=%0d exp=22", o_o); n_bad++; end n_cmp++;
        if (mac_o !== 32'sd22) begin $display("FAIL gemm_mac got=%0d exp=22", mac_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b0)   begin $display("FAIL gemm_sat got=%0d exp=0", sat_o); n_bad++; end n_cmp++;
        tick();
        if (valid_o !== 1'b0) begin $display("FAIL gemm_valid_drop got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd22)  begin $display("FAIL gemm_hold got=%0d exp=22", o_o); n_bad++; end n_cmp++;
        $display("gemm: 3*4+10 -> o=%0d wc=%0d", o_o, wc_o);
    endtask

    task automatic test_saturation();
        drive_op(2'b00, -16'sd32768, -16'sd32768, 32'sd0, 32'sh7FFFFFFF);
        tick(); valid_i = 1'b0; tick();
        if (o_o !== 32'sh7FFFFFFF) begin $display("FAIL sat_pos_o got=%0d exp=2147483647", o_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b1) begin $display("FAIL sat_pos_flag got=%0d exp=1", sat_o); n_bad++; end n_cmp++;
        $display("sat: positive clamp o=%0d sat=%0d", o_o, sat_o);
        drive_op(2'b00, -16'sd32768, 16'sd32767, 32'sd0, 32'sh80000000);
        tick(); valid_i = 1'b0; tick();
        if (o_o !== 32'sh80000000) begin $display("FAIL sat_neg_o got=%0d exp=-2147483648", o_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b1) begin $display("FAIL sat_neg_flag got=%0d exp=1", sat_o); n_bad++; end n_cmp++;
        tick();
        if (sat_o !== 1'b0) begin $display("FAIL sat_clear got=%0d exp=0", sat_o); n_bad++; end n_cmp++;
        $display("sat: negative clamp o=%0d", o_o);
    endtask

    task automatic test_pwl();
        cfg_write(5'b00_000, 16'sd2048, 32'sd100);
        drive_op(2'b01, 16'sd0, 16'sd0, 32'sd1048576, 32'sd0);
        tick(); valid_i = 1'b0;
        if (wc_o !== 16'sd32767) begin $display("FAIL pwl_wc_hold got=%0d exp=32767", wc_o); n_bad++; end n_cmp++;
        tick();
        if (valid_o !== 1'b1) begin $display("FAIL pwl_valid got=%0d exp=1", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd2097252) begin $display("FAIL pwl_o got=%0d exp=2097252", o_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b0) begin $display("FAIL pwl_sat got=%0d exp=0", sat_o); n_bad++; end n_cmp++;
        $display("pwl: div 1024*2048+100 -> o=%0d", o_o);
    endtask

    task automatic test_mac_clamp();
        cfg_write(5'b00_000, 16'sd1, 32'sd0);
        drive_op(2'b01, 16'sd0, 16'sd0, 32'sh7FFFFFFF, 32'sd0);
        tick(); valid_i = 1'b0; tick();
        if (o_o !== 32'sd32767) begin $display("FAIL macclamp_pos got=%0d exp=32767", o_o); n_bad++; end n_cmp++;
        drive_op(2'b01, 16'sd0, 16'sd0, 32'sh80000000, 32'sd0);
        tick(); valid_i = 1'b0; tick();
        if (o_o !== -32'sd32768) begin $display("FAIL macclamp_neg got=%0d exp=-32768", o_o); n_bad++; end n_cmp++;
        if (sat_o !== 1'b0) begin $display("FAIL macclamp_sat got=%0d exp=0", sat_o); n_bad++; end n_cmp++;
        $display("mac clamp: o=%0d", o_o);
    endtask

    task automatic test_tables();
        cfg_write(5'b01_111, 16'sd3, -32'sd5);
        cfg_write(5'b10_011, -16'sd2, 32'sd1000);
        cfg_write(5'b11_011, 16'sd99, 32'sd99);
        drive_op(2'b10, 16'shE000, 16'sd0, 32'sd4096, 32'sd0);
        tick();
        drive_op(2'b11, 16'sh6000, 16'sd0, 32'sd10240, 32'sd0);
        tick(); valid_i = 1'b0;
        if (o_o !== 32'sd7)   begin $display("FAIL exp_tbl got=%0d exp=7", o_o); n_bad++; end n_cmp++;
        tick();
        if (o_o !== 32'sd980) begin $display("FAIL log_tbl got=%0d exp=980", o_o); n_bad++; end n_cmp++;
        $display("tables: exp seg7 -> 7, log seg3 -> %0d", o_o);
    endtask

    task automatic test_read_during_write();
        cfg_write(5'b00_001, 16'sd1, 32'sd0);
        cfg_we_i = 1'b1; cfg_addr_i = 5'b00_001; cfg_scale_i = 16'sd5; cfg_offset_i = 32'sd0;
        drive_op(2'b01, 16'sh2000, 16'sd0, 32'sd7168, 32'sd0);
        tick(); cfg_we_i = 1'b0; valid_i = 1'b0; tick();
        if (o_o !== 32'sd7) begin $display("FAIL rdw_old got=%0d exp=7", o_o); n_bad++; end n_cmp++;
        drive_op(2'b01, 16'sh2000, 16'sd0, 32'sd7168, 32'sd0);
        tick(); valid_i = 1'b0; tick();
        if (o_o !== 32'sd35) begin $display("FAIL rdw_new got=%0d exp=35", o_o); n_bad++; end n_cmp++;
        $display("rdw: same-cycle 7, next op %0d", o_o);
    endtask

    task automatic test_back_to_back();
        drive_op(2'b00, 16'sd5, 16'sd2, 32'sd0, 32'sd1);
        tick();
        drive_op(2'b01, 16'sh2000, 16'sd0, 32'sd3072, 32'sd0);
        tick(); valid_i = 1'b0;
        if (valid_o !== 1'b1) begin $display("FAIL b2b_valid0 got=%0d exp=1", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd11)  begin $display("FAIL b2b_gemm got=%0d exp=11", o_o); n_bad++; end n_cmp++;
        if (wc_o !== 16'sd2)  begin $display("FAIL b2b_wc got=%0d exp=2", wc_o); n_bad++; end n_cmp++;
        tick();
        if (valid_o !== 1'b1) begin $display("FAIL b2b_valid1 got=%0d exp=1", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd15)  begin $display("FAIL b2b_div got=%0d exp=15", o_o); n_bad++; end n_cmp++;
        tick();
        $display("b2b: gemm 11 then div %0d", o_o);
    endtask

    task automatic test_reset_mid();
        cfg_write(5'b00_010, 16'sd4, 32'sd77);
        drive_op(2'b01, 16'sh4000, 16'sd0, 32'sd1024, 32'sd0);
        tick(); valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        if (valid_o !== 1'b0) begin $display("FAIL rstmid_valid got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd0)   begin $display("FAIL rstmid_o got=%0d exp=0", o_o); n_bad++; end n_cmp++;
        if (wc_o !== 16'sd0)  begin $display("FAIL rstmid_wc got=%0d exp=0", wc_o); n_bad++; end n_cmp++;
        tick();
        rst_n = 1'b1;
        tick();
        if (valid_o !== 1'b0) begin $display("FAIL rstmid_novalid0 got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        tick();
        if (valid_o !== 1'b0) begin $display("FAIL rstmid_novalid1 got=%0d exp=0", valid_o); n_bad++; end n_cmp++;
        drive_op(2'b01, 16'sh4000, 16'sd0, 32'sd1024, 32'sd0);
        tick(); valid_i = 1'b0; tick();
        if (valid_o !== 1'b1) begin $display("FAIL rstmid_lookup_valid got=%0d exp=1", valid_o); n_bad++; end n_cmp++;
        if (o_o !== 32'sd0)   begin $display("FAIL rstmid_lookup got=%0d exp=0", o_o); n_bad++; end n_cmp++;
        $display("reset mid-op: lookup after reset o=%0d", o_o);
    endtask

    initial begin
        rst_n = 1'b0; mode_i = 2'b00; valid_i = 1'b0;
        mac_i = '0; o_i = '0; x_i = '0; wc_i = '0;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_scale_i = '0; cfg_offset_i = '0;
        test_reset();
        test_gemm();
        test_saturation();
        test_pwl();
        test_mac_clamp();
        test_tables();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
